// File: rtl/edge_stream_packer_pkg.sv
// Shared word layout for the packed edge stream.
// The downstream frame-buffer writer imports this too, so both sides agree
// on lane order and on where the sof/eol flags sit in a FIFO entry.
package edge_stream_packer_pkg;

  localparam int LANE_W  = 8;
  localparam int LANES   = 4;
  localparam int WORD_W  = LANE_W * LANES;
  localparam int SOF_BIT = WORD_W;
  localparam int EOL_BIT = WORD_W + 1;
  localparam int ENTRY_W = WORD_W + 2;

  // One FIFO entry: {eol, sof, data}, first pixel in data[7:0]
  typedef struct packed {
    logic              eol;
    logic              sof;
    logic [WORD_W-1:0] data;
  } packed_word_t;

endpackage

// File: rtl/edge_stream_packer_if.sv
// Valid/ready word stream carrying packed edge pixels plus frame/line tags.
interface edge_stream_packer_if;
  import edge_stream_packer_pkg::*;

  logic              valid;
  logic              ready;
  logic [WORD_W-1:0] data;
  logic              sof;
  logic              eol;

  modport master (output valid, data, sof, eol, input ready);
  modport slave  (input valid, data, sof, eol, output ready);

endinterface

// File: rtl/edge_stream_packer_fifo.sv
// edge_pack_fifo: first-word-fall-through synchronous FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A write while full is accepted only if a read frees an entry that cycle.
module edge_pack_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_write;
  logic             do_read;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_read  = rd_en && !empty;
  assign do_write = wr_en && (!full || do_read);
  // Head is forced to zero when empty so the port never shows stale data
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage array; contents are only visible through a valid pointer
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer advance on accepted writes and reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/edge_stream_packer.sv
// edge_stream_packer: packs four 8-bit edge pixels into a 32-bit word,
// tags it with sof/eol, and queues it in a FWFT FIFO toward the master port.
// A completed word is registered one cycle before entering the FIFO.
// Words that find the FIFO full are dropped and flagged in sticky overflow.
// Optional macro EDGE_PACK_STATS_EN adds edge_count, the number of nonzero
// pixels in the last completed frame (dropped words included).
module edge_stream_packer
  import edge_stream_packer_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        din_valid,
  input  logic [LANE_W-1:0]           edge_data,
  edge_stream_packer_if.master        m,
  output logic                        overflow,
  output logic                        frame_done
`ifdef EDGE_PACK_STATS_EN
  ,
  output logic [31:0]                 edge_count
`endif
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [XW-1:0]           x;
  logic [YW-1:0]           y;
  logic [3*LANE_W-1:0]     asm_lo;
  packed_word_t            word_q;
  logic                    word_pending;
  logic                    last_x;
  logic                    last_y;
  logic                    fifo_full;
  logic                    fifo_empty;
  packed_word_t            head;

  assign last_x = (x == XW'(IMG_WIDTH - 1));
  assign last_y = (y == YW'(IMG_HEIGHT - 1));

  // Pixel position counters; the first valid pixel after reset is (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (din_valid) begin
      if (last_x) begin
        x <= '0;
        y <= last_y ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Lane assembly; the fourth pixel goes straight into the completed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_lo       <= '0;
      word_q       <= '0;
      word_pending <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      word_pending <= din_valid && (x[1:0] == 2'd3);
      frame_done   <= din_valid && last_x && last_y;
      if (din_valid) begin
        case (x[1:0])
          2'd0: asm_lo[7:0]   <= edge_data;
          2'd1: asm_lo[15:8]  <= edge_data;
          2'd2: asm_lo[23:16] <= edge_data;
          default: begin
            word_q.data <= {edge_data, asm_lo};
            word_q.sof  <= (x == XW'(3)) && (y == '0);
            word_q.eol  <= last_x;
          end
        endcase
      end
    end
  end

  // Sticky overflow: pending word meets a full FIFO with no read to free it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (word_pending && fifo_full && !m.ready) overflow <= 1'b1;
  end

  edge_pack_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (word_pending),
    .wr_data (word_q),
    .rd_en   (m.ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m.valid = !fifo_empty;
  assign m.data  = head.data;
  assign m.sof   = head.sof;
  assign m.eol   = head.eol;

`ifdef EDGE_PACK_STATS_EN
  logic [31:0] edge_acc;
  logic        pix_nz;

  assign pix_nz = (edge_data != '0);

  // Per-frame nonzero pixel count, published when the last pixel is sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_acc   <= '0;
      edge_count <= '0;
    end else if (din_valid) begin
      if (last_x && last_y) begin
        edge_count <= edge_acc + 32'(pix_nz);
        edge_acc   <= '0;
      end else begin
        edge_acc   <= edge_acc + 32'(pix_nz);
      end
    end
  end
`endif

endmodule

// File: tb/tb_edge_stream_packer.sv
// Directed bench for edge_stream_packer on an 8x2 image with a 4-deep FIFO.
// Accepted words are collected at the falling edge; each test task checks
// its own hand-computed expectations.
module tb_edge_stream_packer;
  import edge_stream_packer_pkg::*;

  localparam int W = 8;
  localparam int H = 2;
  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic       din_valid;
  logic [7:0] edge_data;
  logic       overflow;
  logic       frame_done;
`ifdef EDGE_PACK_STATS_EN
  logic [31:0] edge_count;
`endif

  int vectors;
  int miscompares;
  int fd_count;
  packed_word_t rx_q[$];

  edge_stream_packer_if m_if ();

  edge_stream_packer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .edge_data  (edge_data),
    .m          (m_if),
    .overflow   (overflow),
    .frame_done (frame_done)
`ifdef EDGE_PACK_STATS_EN
    ,
    .edge_count (edge_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted words and frame_done pulses at the falling edge
  always @(negedge clk) begin
    if (rst_n && m_if.valid && m_if.ready)
      rx_q.push_back(packed_word_t'({m_if.eol, m_if.sof, m_if.data}));
    if (rst_n && frame_done) fd_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [7:0] p);
    din_valid = 1'b1;
    edge_data = p;
    tick();
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    din_valid  = 1'b0;
    edge_data  = 8'h00;
    m_if.ready = 1'b0;
    rst_n      = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    rx_q.delete();
    fd_count = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 6;
    if (m_if.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", m_if.valid); end
    if (m_if.data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data got %h want 0", m_if.data); end
    if (m_if.sof !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sof got %b want 0", m_if.sof); end
    if (m_if.eol !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_eol got %b want 0", m_if.eol); end
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
    if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); end
`ifdef EDGE_PACK_STATS_EN
    vectors++;
    if (edge_count !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_edge_count got %0d want 0", edge_count); end
`endif
  endtask

  task automatic test_first_word();
    do_reset();
    m_if.ready = 1'b1;
    send_pixel(8'h00);
    send_pixel(8'hFF);
    send_pixel(8'hFF);
    send_pixel(8'h00);
    din_valid = 1'b0;
    vectors++;
    if (m_if.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL first_valid_early got %b want 0", m_if.valid); end
    tick();
    vectors += 4;
    if (m_if.valid !== 1'b1) begin miscompares++; $display("[TB] FAIL first_valid got %b want 1", m_if.valid); end
    if (m_if.data !== 32'h00FFFF00) begin miscompares++; $display("[TB] FAIL first_data got %h want 00ffff00", m_if.data); end
    if (m_if.sof !== 1'b1) begin miscompares++; $display("[TB] FAIL first_sof got %b want 1", m_if.sof); end
    if (m_if.eol !== 1'b0) begin miscompares++; $display("[TB] FAIL first_eol got %b want 0", m_if.eol); end
    tick();
    vectors++;
    if (m_if.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL first_drained got %b want 0", m_if.valid); end
  endtask

  task automatic test_frame();
    logic [31:0] exp_data [4];
    logic        exp_sof  [4];
    logic        exp_eol  [4];
    exp_data = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    exp_sof  = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_eol  = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    m_if.ready = 1'b1;
    for (int i = 0; i < 16; i++) send_pixel(8'(i));
    idle(4);
    vectors += 2;
    if (rx_q.size() !== 4) begin miscompares++; $display("[TB] FAIL frame_word_count got %0d want 4", rx_q.size()); end
    if (fd_count !== 1) begin miscompares++; $display("[TB] FAIL frame_done_count got %0d want 1", fd_count); end
    for (int k = 0; k < 4; k++) begin
      if (k < rx_q.size()) begin
        vectors += 3;
        if (rx_q[k].data !== exp_data[k]) begin miscompares++; $display("[TB] FAIL frame_data[%0d] got %h want %h", k, rx_q[k].data, exp_data[k]); end
        if (rx_q[k].sof !== exp_sof[k]) begin miscompares++; $display("[TB] FAIL frame_sof[%0d] got %b want %b", k, rx_q[k].sof, exp_sof[k]); end
        if (rx_q[k].eol !== exp_eol[k]) begin miscompares++; $display("[TB] FAIL frame_eol[%0d] got %b want %b", k, rx_q[k].eol, exp_eol[k]); end
      end
    end
    for (int i = 16; i < 20; i++) send_pixel(8'(i));
    idle(4);
    vectors++;
    if (rx_q.size() !== 5) begin
      miscompares++; $display("[TB] FAIL next_frame_count got %0d want 5", rx_q.size());
    end else begin
      vectors += 2;
      if (rx_q[4].sof !== 1'b1) begin miscompares++; $display("[TB] FAIL next_frame_sof got %b want 1", rx_q[4].sof); end
      if (rx_q[4].data !== 32'h13121110) begin miscompares++; $display("[TB] FAIL next_frame_data got %h want 13121110", rx_q[4].data); end
    end
    vectors++;
    if (fd_count !== 1) begin miscompares++; $display("[TB] FAIL frame_done_recount got %0d want 1", fd_count); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_data [4];
    exp_data = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send_pixel(8'(i));
      if (i >= 4) begin
        vectors += 2;
        if (m_if.valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_valid[%0d] got %b want 1", i, m_if.valid); end
        if (m_if.data !== 32'h03020100) begin miscompares++; $display("[TB] FAIL stall_data[%0d] got %h want 03020100", i, m_if.data); end
      end
      if (i == 19) begin
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL overflow_early got %b want 0", overflow); end
      end
    end
    idle(2);
    vectors += 2;
    if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_set got %b want 1", overflow); end
    if (m_if.data !== 32'h03020100) begin miscompares++; $display("[TB] FAIL stall_head got %h want 03020100", m_if.data); end
    m_if.ready = 1'b1;
    idle(6);
    vectors += 3;
    if (rx_q.size() !== 4) begin miscompares++; $display("[TB] FAIL overflow_word_count got %0d want 4", rx_q.size()); end
    if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_sticky got %b want 1", overflow); end
    if (m_if.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL overflow_drained got %b want 0", m_if.valid); end
    for (int k = 0; k < 4; k++) begin
      if (k < rx_q.size()) begin
        vectors++;
        if (rx_q[k].data !== exp_data[k]) begin miscompares++; $display("[TB] FAIL overflow_data[%0d] got %h want %h", k, rx_q[k].data, exp_data[k]); end
      end
    end
  endtask

  task automatic test_full_write();
    do_reset();
    for (int i = 0; i < 20; i++) send_pixel(8'(i));
    din_valid  = 1'b0;
    m_if.ready = 1'b1;
    tick();
    m_if.ready = 1'b0;
    idle(2);
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL full_write_overflow got %b want 0", overflow); end
    m_if.ready = 1'b1;
    idle(6);
    vectors += 2;
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL full_write_overflow_late got %b want 0", overflow); end
    if (rx_q.size() !== 5) begin
      miscompares++; $display("[TB] FAIL full_write_count got %0d want 5", rx_q.size());
    end else begin
      vectors += 2;
      if (rx_q[0].data !== 32'h03020100) begin miscompares++; $display("[TB] FAIL full_write_first got %h want 03020100", rx_q[0].data); end
      if (rx_q[4].data !== 32'h13121110) begin miscompares++; $display("[TB] FAIL full_write_last got %h want 13121110", rx_q[4].data); end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    m_if.ready = 1'b1;
    for (int i = 0; i < 6; i++) send_pixel(8'hA0 + 8'(i));
    din_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rx_q.delete();
    send_pixel(8'h01);
    send_pixel(8'h02);
    send_pixel(8'h03);
    send_pixel(8'h04);
    idle(4);
    vectors++;
    if (rx_q.size() !== 1) begin
      miscompares++; $display("[TB] FAIL midreset_count got %0d want 1", rx_q.size());
    end else begin
      vectors += 2;
      if (rx_q[0].data !== 32'h04030201) begin miscompares++; $display("[TB] FAIL midreset_data got %h want 04030201", rx_q[0].data); end
      if (rx_q[0].sof !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_sof got %b want 1", rx_q[0].sof); end
    end
  endtask

`ifdef EDGE_PACK_STATS_EN
  task automatic test_stats();
    do_reset();
    m_if.ready = 1'b1;
    for (int i = 0; i < 16; i++)
      send_pixel((i == 0 || i == 5 || i == 9 || i == 14 || i == 15) ? 8'hFF : 8'h00);
    idle(2);
    vectors++;
    if (edge_count !== 32'd5) begin miscompares++; $display("[TB] FAIL stats_edge_count got %0d want 5", edge_count); end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    fd_count    = 0;
    rst_n       = 1'b0;
    din_valid   = 1'b0;
    edge_data   = 8'h00;
    m_if.ready  = 1'b0;
    test_reset();
    test_first_word();
    test_frame();
    test_overflow();
    test_full_write();
    test_reset_midframe();
`ifdef EDGE_PACK_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
